// File: rtl/fifo_stream_reader_pkg.sv
// Shared definitions for the async FIFO family: reader state encoding,
// default data width and the index-width helper.
package fifo_stream_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } reader_state_e;

  localparam int DEFAULT_DATA_WIDTH = 16;

  // Width of a 0..n-1 index; a one-beat packet still needs a 1-bit register.
  function automatic int idx_width(input int n);
    if (n <= 1) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry valid/ready buffer. The head entry drives the output and stays
// stable while stalled; occupancy feeds the upstream issue decision.
module stream_skid_buf #(
  parameter int WIDTH = 17
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_payload,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_payload,
  output logic [1:0]       occupancy
);

  logic [WIDTH-1:0] head_r;
  logic [WIDTH-1:0] tail_r;
  logic [1:0]       cnt_r;
  logic             pop_s;

  assign out_valid   = (cnt_r != 2'd0);
  assign out_payload = head_r;
  assign occupancy   = cnt_r;
  assign pop_s       = out_valid & out_ready;

  // Head/tail storage; a push into a full buffer is prevented upstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_r <= {WIDTH{1'b0}};
      tail_r <= {WIDTH{1'b0}};
      cnt_r  <= 2'd0;
    end else begin
      case (cnt_r)
        2'd0: begin
          if (in_valid) begin
            head_r <= in_payload;
            cnt_r  <= 2'd1;
          end
        end
        2'd1: begin
          case ({in_valid, pop_s})
            2'b10: begin
              tail_r <= in_payload;
              cnt_r  <= 2'd2;
            end
            2'b01: cnt_r  <= 2'd0;
            2'b11: head_r <= in_payload;
            default: ;
          endcase
        end
        2'd2: begin
          if (pop_s) begin
            head_r <= tail_r;
            if (in_valid) begin
              tail_r <= in_payload;
            end else begin
              cnt_r <= 2'd1;
            end
          end
        end
        default: cnt_r <= 2'd0;
      endcase
    end
  end

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side FIFO consumer: pops with a registered 1-cycle read latency and
// re-presents the words as a framed valid/ready stream, stopping on packet edges.
module fifo_stream_reader
  import fifo_stream_reader_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int PKT_LEN    = 4,
  parameter int PCNT_WIDTH = 16
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst_n,
  input  logic                  enable,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic [PCNT_WIDTH-1:0] pkt_cnt
);

  localparam int IDX_W = idx_width(PKT_LEN);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PKT_LEN - 1);

  reader_state_e         state_r;
  logic [IDX_W-1:0]      issue_idx_r;
  logic                  infl_r;
  logic                  infl_last_r;
  logic [PCNT_WIDTH-1:0] pkt_cnt_r;
  logic [1:0]            buf_cnt_s;
  logic [DATA_WIDTH:0]   head_s;
  logic                  pop_s;
  logic                  allow_s;
  logic [2:0]            occ_s;

  stream_skid_buf #(
    .WIDTH(DATA_WIDTH + 1)
  ) u_buf (
    .clk        (rd_clk),
    .rst_n      (rd_rst_n),
    .in_valid   (infl_r),
    .in_payload ({infl_last_r, fifo_rd_data}),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_payload(head_s),
    .occupancy  (buf_cnt_s)
  );

  assign out_last = head_s[DATA_WIDTH];
  assign out_data = head_s[DATA_WIDTH-1:0];
  assign pop_s    = out_valid & out_ready;
  assign busy     = (state_r != ST_IDLE);
  assign pkt_cnt  = pkt_cnt_r;

  // Slots committed after this edge: buffered + in flight - leaving now.
  assign occ_s      = {1'b0, buf_cnt_s} + {2'b00, infl_r} - {2'b00, pop_s};
  assign fifo_rd_en = allow_s & ~fifo_empty & (occ_s < 3'd2);

  // Issue permission per state; DRAIN only finishes a started packet.
  always_comb begin
    allow_s = 1'b0;
    case (state_r)
      ST_IDLE:  allow_s = 1'b0;
      ST_RUN:   allow_s = 1'b1;
      ST_DRAIN: allow_s = (issue_idx_r != IDX_W'(0));
      default:  allow_s = 1'b0;
    endcase
  end

  // In-flight tracking and beat-position counter for accepted pops.
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      infl_r      <= 1'b0;
      infl_last_r <= 1'b0;
      issue_idx_r <= IDX_W'(0);
    end else begin
      infl_r      <= fifo_rd_en;
      infl_last_r <= fifo_rd_en & (issue_idx_r == IDX_LAST);
      if (fifo_rd_en) begin
        issue_idx_r <= (issue_idx_r == IDX_LAST) ? IDX_W'(0) : issue_idx_r + IDX_W'(1);
      end
    end
  end

  // Completed-packet counter, wrapping.
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      pkt_cnt_r <= {PCNT_WIDTH{1'b0}};
    end else if (pop_s && out_last) begin
      pkt_cnt_r <= pkt_cnt_r + PCNT_WIDTH'(1);
    end
  end

  // Reader FSM.
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (enable) state_r <= ST_RUN;
        end
        ST_RUN: begin
          if (!enable) state_r <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (enable) begin
            state_r <= ST_RUN;
          end else if ((issue_idx_r == IDX_W'(0)) && !infl_r && (buf_cnt_s == 2'd0)) begin
            state_r <= ST_IDLE;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

endmodule
